// File: rtl/fp_pkg.sv
// Shared single-precision constants, IEEE-754 single layout and the converter state type.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } cvt_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized magnitude (hidden bit dropped) into a 23-bit mantissa.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] exp_pre,
    input  logic [30:0]      mag,
    output logic [EXP_W-1:0] exp_rnd,
    output logic [MAN_W-1:0] man_rnd,
    output logic             inexact
);

    logic             guard;
    logic             sticky;
    logic             inc;
    logic [MAN_W:0]   sum;

    assign guard   = mag[7];
    assign sticky  = |mag[6:0];
    assign inc     = guard & (sticky | mag[8]);
    assign sum     = {1'b0, mag[30:8]} + {{MAN_W{1'b0}}, inc};
    // A carry out leaves the mantissa at zero and bumps the exponent by one.
    assign man_rnd = sum[MAN_W-1:0];
    assign exp_rnd = exp_pre + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
    assign inexact = guard | sticky;

endmodule

// File: rtl/int_to_fp_converter.sv
// Signed integer to IEEE-754 single converter with iterative normalization and RNE rounding.
// Define FP_CVT_FAST_NORM_EN to normalize in 8-bit steps while the top byte is zero.
module int_to_fp_converter
    import fp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_int,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_fp,
    output logic            out_inexact
);

    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + XLEN - 1);

    cvt_state_t       state, state_nxt;
    logic             sign;
    logic [XLEN-1:0]  mag;
    logic [EXP_W-1:0] exp;
    logic [XLEN-1:0]  abs_int;
    logic             accept;
    logic [EXP_W-1:0] rexp;
    logic [MAN_W-1:0] rman;
    logic             rinexact;
    fp32_t            res;

    // Two's-complement negate; -2^31 wraps to 0x80000000, which is the right magnitude.
    assign abs_int = in_int[XLEN-1] ? (~in_int + 1'b1) : in_int;
    assign accept  = in_valid & in_ready;

    fp_round_rne u_round (
        .exp_pre (exp),
        .mag     (mag[30:0]),
        .exp_rnd (rexp),
        .man_rnd (rman),
        .inexact (rinexact)
    );

    assign res = '{sign: sign, exp: rexp, man: rman};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (in_int == '0) ? DONE : NORM;
            NORM:    if (mag[XLEN-1]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            mag         <= '0;
            exp         <= '0;
            out_fp      <= '0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign        <= in_int[XLEN-1];
                    mag         <= abs_int;
                    exp         <= EXP_INIT;
                    // Zero goes straight to DONE, so the cleared result is the answer.
                    out_fp      <= '0;
                    out_inexact <= 1'b0;
                end
                NORM: if (!mag[XLEN-1]) begin
`ifdef FP_CVT_FAST_NORM_EN
                    if (mag[XLEN-1 -: 8] == 8'd0) begin
                        mag <= mag << 8;
                        exp <= exp - EXP_W'(8);
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 1'b1;
                    end
`else
                    mag <= mag << 1;
                    exp <= exp - 1'b1;
`endif
                end
                ROUND: begin
                    out_fp      <= res;
                    out_inexact <= rinexact;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed-vector bench for int_to_fp_converter: results, flags, latency, backpressure, reset abort.
module tb_int_to_fp_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_inexact;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_to_fp_converter #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fp      (out_fp),
        .out_inexact (out_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Latency counts edges after the acceptance edge until out_valid is seen.
    task automatic convert(input logic [31:0] val, input logic [31:0] efp, input logic einx,
                           input int elat, input bit poke, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_int   = val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (poke) begin
                in_valid = lat[0];
                in_int   = 32'hDEAD0000 | lat;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_out_fp"}, out_fp, efp);
        chk({tag, "_inexact"}, {31'd0, out_inexact}, {31'd0, einx});
    endtask

    task automatic pop(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_pop_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_int    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_fp", out_fp, 32'd0);
        chk("rst_inexact", {31'd0, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3: lz=30 -> 32 edges
        convert(32'd3, 32'h40400000, 1'b0, 32, 1'b0, "three");
        // Backpressure with a new value offered while DONE
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            in_int    = 32'h12345678;
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_fp", out_fp, 32'h40400000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        pop("three");

        // -6 with in_valid toggling during NORM; lz(6)=29
        convert(-32'sd6, 32'hC0C00000, 1'b0, 31, 1'b1, "neg6");
        pop("neg6");

        // Zero: DONE right after the acceptance edge
        convert(32'd0, 32'h00000000, 1'b0, 0, 1'b0, "zero");
        pop("zero");

        convert(32'h80000000, 32'hCF000000, 1'b0, 2, 1'b0, "minint");
        pop("minint");

        // Tie cases: lz=7
        convert(32'd16777217, 32'h4B800000, 1'b1, 9, 1'b0, "tie_even");
        pop("tie_even");
        convert(32'd16777219, 32'h4B800002, 1'b1, 9, 1'b0, "tie_up");
        pop("tie_up");

        // Mantissa carry-out: lz=1
        convert(32'h7FFFFFFF, 32'h4F000000, 1'b1, 3, 1'b0, "carry");
        pop("carry");

        // Reset in the middle of normalizing 1 (lz=31)
        @(negedge clk);
        in_int   = 32'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_fp", out_fp, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(32'd5, 32'h40A00000, 1'b0, 31, 1'b0, "five");
        pop("five");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
